alu_cmd_sequencer: RTL and testbench

Upstream stage of the ALU. It accepts 12-bit command words on a run strobe and decodes them. It holds a 4-entry x 32-bit operand register file, drives the ALU operand and op-code inputs from registered values, and writes the ALU result back into the file. Commands are processed one at a time through a small FSM, with a ready/done handshake to the command source.

---
 rtl/alu_cmd_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
//-----------------------------------------------------------------------------
// alu_cmd_sequencer
//
// Upstream command stage of the ALU. Accepts 12-bit command words on a run
// strobe, decodes them, and either loads an immediate into the 4 x DATA_WIDTH
// operand register file or drives the ALU with registered operands and
// writes the ALU result back. One command is processed at a time through an
// IDLE -> DECODE (-> EXEC) state machine.
//
// Command encoding:
//   cmd[11]    = 0  : ALU op  [10:8] op, [7:6] rd, [5:4] rs1, [3:2] rs2,
//                             [1:0] reserved, must be 00 (else illegal)
//   cmd[11:10] = 10 : LOADI   [9:8] rd, [7:0] imm ; rd = zero-extended imm
//   cmd[11:10] = 11 : SHL8I   [9:8] rd, [7:0] imm ; rd = (rd << 8) | imm
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous, active-high reset
//   command      in   12-bit command word, sampled when run && ready
//   run          in   command strobe, one command per high cycle
//   ready        out  high while the sequencer is idle
//   alu_op_code  out  registered ALU op code
//   data_a       out  registered ALU operand A
//   data_b       out  registered ALU operand B
//   y            in   ALU result (combinational from data_a/data_b/op)
//   O, C, Z, N   in   ALU flags
//   done         out  one-cycle pulse when a command retires
//   result       out  value written to rd by the last retired command
//   illegal_cmd  out  one-cycle pulse when a command is rejected
//   cmd_overflow out  sticky; set when run arrives while busy
//   status       out  {O,C,Z,N} of the last ALU retire (STATUS_REG_EN only)
//
// Optional feature macro: STATUS_REG_EN
//   Defined   : status port exists and captures the ALU flags on ALU retire.
//   Undefined : no status port, the flag inputs are ignored.
//-----------------------------------------------------------------------------
module alu_cmd_sequencer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [11:0]           command,
    input  logic                  run,
    output logic                  ready,
    output logic [2:0]            alu_op_code,
    output logic [DATA_WIDTH-1:0] data_a,
    output logic [DATA_WIDTH-1:0] data_b,
    input  logic [DATA_WIDTH-1:0] y,
    input  logic                  O,
    input  logic                  C,
    input  logic                  Z,
    input  logic                  N,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  illegal_cmd,
    output logic                  cmd_overflow
`ifdef STATUS_REG_EN
    ,
    output logic [3:0]            status
`endif
);

    // The immediate width is tied to the command encoding.
    localparam int IMM_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2
    } state_t;

    state_t                state;
    logic [11:0]           cmd_reg;
    logic [DATA_WIDTH-1:0] regs [4];

    // Decoded fields of the latched command
    logic                  is_alu;
    logic                  is_shl;
    logic [2:0]            alu_op;
    logic [1:0]            alu_rd;
    logic [1:0]            alu_rs1;
    logic [1:0]            alu_rs2;
    logic [1:0]            alu_rsvd;
    logic [1:0]            imm_rd;
    logic [IMM_WIDTH-1:0]  imm;
    logic [DATA_WIDTH-1:0] imm_value;

    assign ready = (state == IDLE);

    // Field extraction. The immediate write value is computed here so the
    // FSM only has to pick the destination; SHL8I drops the top byte of rd.
    always_comb begin
        is_alu    = ~cmd_reg[11];
        is_shl    = cmd_reg[10];
        alu_op    = cmd_reg[10:8];
        alu_rd    = cmd_reg[7:6];
        alu_rs1   = cmd_reg[5:4];
        alu_rs2   = cmd_reg[3:2];
        alu_rsvd  = cmd_reg[1:0];
        imm_rd    = cmd_reg[9:8];
        imm       = cmd_reg[IMM_WIDTH-1:0];
        imm_value = {{(DATA_WIDTH-IMM_WIDTH){1'b0}}, imm};
        if (is_shl) begin
            imm_value = {regs[imm_rd][DATA_WIDTH-IMM_WIDTH-1:0], imm};
        end
    end

    // Main sequencer. done and illegal_cmd default low every cycle so they
    // only pulse for the single cycle after the edge that sets them. The
    // overflow flag watches run independently of the state transitions.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cmd_reg      <= '0;
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
            data_a       <= '0;
            data_b       <= '0;
            alu_op_code  <= '0;
            result       <= '0;
            done         <= 1'b0;
            illegal_cmd  <= 1'b0;
            cmd_overflow <= 1'b0;
        end else begin
            done        <= 1'b0;
            illegal_cmd <= 1'b0;

            if (run && !ready) begin
                cmd_overflow <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (run) begin
                        cmd_reg <= command;
                        state   <= DECODE;
                    end
                end

                DECODE: begin
                    if (!is_alu) begin
                        regs[imm_rd] <= imm_value;
                        result       <= imm_value;
                        done         <= 1'b1;
                        state        <= IDLE;
                    end else if (alu_rsvd != 2'b00) begin
                        // Rejected: operand/op registers keep their values.
                        illegal_cmd <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        data_a      <= regs[alu_rs1];
                        data_b      <= regs[alu_rs2];
                        alu_op_code <= alu_op;
                        state       <= EXEC;
                    end
                end

                EXEC: begin
                    regs[alu_rd] <= y;
                    result       <= y;
                    done         <= 1'b1;
                    state        <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef STATUS_REG_EN
    // Flags are captured only when an ALU command retires.
    always_ff @(posedge clk) begin
        if (rst) begin
            status <= 4'b0000;
        end else if (state == EXEC) begin
            status <= {O, C, Z, N};
        end
    end
`else
    logic unused_flags;
    assign unused_flags = ^{O, C, Z, N};
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
//-----------------------------------------------------------------------------
// tb_alu_cmd_sequencer
//
// Directed testbench for alu_cmd_sequencer. A small ALU stub (y = a + b with
// add-derived flags) closes the loop. Each scenario task drives its own
// commands and compares outputs one cycle at a time against hand-computed
// values, sampling #1 after the rising edge.
//-----------------------------------------------------------------------------
module tb_alu_cmd_sequencer;

    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic [11:0]   command;
    logic          run;
    logic          ready;
    logic [2:0]    alu_op_code;
    logic [DW-1:0] data_a;
    logic [DW-1:0] data_b;
    logic [DW-1:0] y;
    logic          O, C, Z, N;
    logic          done;
    logic [DW-1:0] result;
    logic          illegal_cmd;
    logic          cmd_overflow;
`ifdef STATUS_REG_EN
    logic [3:0]    status;
`endif

    int checks = 0;
    int errors = 0;

    alu_cmd_sequencer #(.DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .command      (command),
        .run          (run),
        .ready        (ready),
        .alu_op_code  (alu_op_code),
        .data_a       (data_a),
        .data_b       (data_b),
        .y            (y),
        .O            (O),
        .C            (C),
        .Z            (Z),
        .N            (N),
        .done         (done),
        .result       (result),
        .illegal_cmd  (illegal_cmd),
        .cmd_overflow (cmd_overflow)
`ifdef STATUS_REG_EN
        ,
        .status       (status)
`endif
    );

    // ALU stub: adder with carry, signed overflow, zero and negative flags
    logic [DW:0] sum;
    always_comb begin
        sum = {1'b0, data_a} + {1'b0, data_b};
        y   = sum[DW-1:0];
        C   = sum[DW];
        Z   = (sum[DW-1:0] == '0);
        N   = sum[DW-1];
        O   = (data_a[DW-1] == data_b[DW-1]) && (sum[DW-1] != data_a[DW-1]);
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global time bound so the run always terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a command for exactly one cycle; returns #1 after the accepting edge
    task automatic send(input logic [11:0] c);
        command = c;
        run     = 1'b1;
        tick();
        run     = 1'b0;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        rst = 1'b1;
        run = 1'b0;
        command = 12'h000;
        tick();
        tick();
        checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (data_a !== 32'h0) begin errors++; $display("[TB] FAIL reset_data_a: got %h expected 0", data_a); end
        checks++; if (data_b !== 32'h0) begin errors++; $display("[TB] FAIL reset_data_b: got %h expected 0", data_b); end
        checks++; if (alu_op_code !== 3'd0) begin errors++; $display("[TB] FAIL reset_op: got %0d expected 0", alu_op_code); end
        checks++; if (result !== 32'h0) begin errors++; $display("[TB] FAIL reset_result: got %h expected 0", result); end
        checks++; if (illegal_cmd !== 1'b0) begin errors++; $display("[TB] FAIL reset_illegal: got %b expected 0", illegal_cmd); end
        checks++; if (cmd_overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b expected 0", cmd_overflow); end
`ifdef STATUS_REG_EN
        checks++; if (status !== 4'b0000) begin errors++; $display("[TB] FAIL reset_status: got %b expected 0000", status); end
`endif
        // rst and run together: the command must be dropped
        command = 12'h905;
        run     = 1'b1;
        tick();
        rst = 1'b0;
        run = 1'b0;
        checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_run_ready: got %b expected 1", ready); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL rst_run_done: got %b expected 0", done); end
        checks++; if (result !== 32'h0) begin errors++; $display("[TB] FAIL rst_run_result: got %h expected 0", result); end
    endtask

    task automatic test_loadi();
        $display("[TB] test_loadi");
        send(12'h905);
        checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL loadi_busy: got %b expected 0", ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL loadi_early_done: got %b expected 0", done); end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL loadi1_done: got %b expected 1", done); end
        checks++; if (result !== 32'h5) begin errors++; $display("[TB] FAIL loadi1_result: got %h expected 00000005", result); end
        checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL loadi1_ready: got %b expected 1", ready); end
    endtask

    task automatic test_back_to_back();
        $display("[TB] test_back_to_back");
        // Issued in the done cycle of the previous LOADI
        send(12'hA03);
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL b2b_gap_done: got %b expected 0", done); end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_done: got %b expected 1", done); end
        checks++; if (result !== 32'h3) begin errors++; $display("[TB] FAIL b2b_result: got %h expected 00000003", result); end
    endtask

    task automatic test_alu();
        $display("[TB] test_alu");
        send(12'h2D8);
        tick();
        checks++; if (data_a !== 32'h5) begin errors++; $display("[TB] FAIL alu_data_a: got %h expected 00000005", data_a); end
        checks++; if (data_b !== 32'h3) begin errors++; $display("[TB] FAIL alu_data_b: got %h expected 00000003", data_b); end
        checks++; if (alu_op_code !== 3'd2) begin errors++; $display("[TB] FAIL alu_op: got %0d expected 2", alu_op_code); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL alu_early_done: got %b expected 0", done); end
        checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL alu_exec_ready: got %b expected 0", ready); end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL alu_done: got %b expected 1", done); end
        checks++; if (result !== 32'h8) begin errors++; $display("[TB] FAIL alu_result: got %h expected 00000008", result); end
        // Read r3 back through both operands: op0, rd0, rs1=3, rs2=3
        send(12'h03C);
        tick();
        checks++; if (data_a !== 32'h8) begin errors++; $display("[TB] FAIL r3_readback_a: got %h expected 00000008", data_a); end
        checks++; if (data_b !== 32'h8) begin errors++; $display("[TB] FAIL r3_readback_b: got %h expected 00000008", data_b); end
        checks++; if (alu_op_code !== 3'd0) begin errors++; $display("[TB] FAIL r3_readback_op: got %0d expected 0", alu_op_code); end
        tick();
        checks++; if (result !== 32'h10) begin errors++; $display("[TB] FAIL r3_readback_result: got %h expected 00000010", result); end
    endtask

    task automatic test_shl8i();
        logic [31:0] expect_tab [5];
        expect_tab[0] = 32'h0005ABFF;
        expect_tab[1] = 32'h05ABFFFF;
        expect_tab[2] = 32'hABFFFFFF;
        expect_tab[3] = 32'hFFFFFFFF;
        expect_tab[4] = 32'hFFFFFFFF;
        $display("[TB] test_shl8i");
        send(12'h905);
        tick();
        send(12'hDAB);
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL shl_done: got %b expected 1", done); end
        checks++; if (result !== 32'h5AB) begin errors++; $display("[TB] FAIL shl_result: got %h expected 000005ab", result); end
        for (int i = 0; i < 5; i++) begin
            send(12'hDFF);
            tick();
            checks++; if (result !== expect_tab[i]) begin errors++; $display("[TB] FAIL shl_ff_%0d: got %h expected %h", i, result, expect_tab[i]); end
        end
    endtask

    task automatic test_illegal();
        $display("[TB] test_illegal");
        // op 7, rd3, rs1=1, rs2=3, reserved 01; r1 = ffffffff would show if loaded
        send(12'h7DD);
        tick();
        checks++; if (illegal_cmd !== 1'b1) begin errors++; $display("[TB] FAIL illegal_pulse: got %b expected 1", illegal_cmd); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL illegal_done: got %b expected 0", done); end
        checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL illegal_ready: got %b expected 1", ready); end
        checks++; if (data_a !== 32'h8) begin errors++; $display("[TB] FAIL illegal_data_a: got %h expected 00000008", data_a); end
        checks++; if (data_b !== 32'h8) begin errors++; $display("[TB] FAIL illegal_data_b: got %h expected 00000008", data_b); end
        checks++; if (alu_op_code !== 3'd0) begin errors++; $display("[TB] FAIL illegal_op: got %0d expected 0", alu_op_code); end
        tick();
        checks++; if (illegal_cmd !== 1'b0) begin errors++; $display("[TB] FAIL illegal_one_cycle: got %b expected 0", illegal_cmd); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL illegal_late_done: got %b expected 0", done); end
    endtask

    task automatic test_overflow();
        $display("[TB] test_overflow");
        // r1 = ffffffff, r2 = 3, so r3 = 2 after wrap
        command = 12'h2D8;
        run     = 1'b1;
        tick();
        checks++; if (cmd_overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_not_yet: got %b expected 0", cmd_overflow); end
        tick();
        checks++; if (cmd_overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set: got %b expected 1", cmd_overflow); end
        tick();
        run = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL ovf_done: got %b expected 1", done); end
        checks++; if (result !== 32'h2) begin errors++; $display("[TB] FAIL ovf_result: got %h expected 00000002", result); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL ovf_extra_done_%0d: got %b expected 0", i, done); end
            checks++; if (cmd_overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky_%0d: got %b expected 1", i, cmd_overflow); end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (cmd_overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_cleared: got %b expected 0", cmd_overflow); end
    endtask

    task automatic test_reset_mid_exec();
        $display("[TB] test_reset_mid_exec");
        send(12'h811); tick();
        send(12'h905); tick();
        send(12'hA03); tick();
        send(12'hB22); tick();
        send(12'h2D8);
        tick();
        checks++; if (data_a !== 32'h5) begin errors++; $display("[TB] FAIL mid_setup_a: got %h expected 00000005", data_a); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL mid_done: got %b expected 0", done); end
        checks++; if (data_a !== 32'h0) begin errors++; $display("[TB] FAIL mid_data_a: got %h expected 0", data_a); end
        checks++; if (data_b !== 32'h0) begin errors++; $display("[TB] FAIL mid_data_b: got %h expected 0", data_b); end
        checks++; if (alu_op_code !== 3'd0) begin errors++; $display("[TB] FAIL mid_op: got %0d expected 0", alu_op_code); end
        checks++; if (result !== 32'h0) begin errors++; $display("[TB] FAIL mid_result: got %h expected 0", result); end
        checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_ready: got %b expected 1", ready); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL mid_late_done: got %b expected 0", done); end
        // Read r0/r3 then r1/r2; all must be cleared
        send(12'h00C);
        tick();
        checks++; if (data_a !== 32'h0) begin errors++; $display("[TB] FAIL mid_r0: got %h expected 0", data_a); end
        checks++; if (data_b !== 32'h0) begin errors++; $display("[TB] FAIL mid_r3: got %h expected 0", data_b); end
        tick();
        send(12'h018);
        tick();
        checks++; if (data_a !== 32'h0) begin errors++; $display("[TB] FAIL mid_r1: got %h expected 0", data_a); end
        checks++; if (data_b !== 32'h0) begin errors++; $display("[TB] FAIL mid_r2: got %h expected 0", data_b); end
        tick();
        send(12'h905);
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL mid_recover_done: got %b expected 1", done); end
        checks++; if (result !== 32'h5) begin errors++; $display("[TB] FAIL mid_recover_result: got %h expected 00000005", result); end
    endtask

`ifdef STATUS_REG_EN
    task automatic test_status();
        $display("[TB] test_status");
        send(12'h900); tick();
        send(12'hA00); tick();
        send(12'h2D8); tick(); tick();
        checks++; if (result !== 32'h0) begin errors++; $display("[TB] FAIL status_result: got %h expected 0", result); end
        checks++; if (status !== 4'b0010) begin errors++; $display("[TB] FAIL status_zero: got %b expected 0010", status); end
        send(12'h905); tick();
        checks++; if (status !== 4'b0010) begin errors++; $display("[TB] FAIL status_hold: got %b expected 0010", status); end
    endtask
`endif

    initial begin
        rst     = 1'b1;
        run     = 1'b0;
        command = 12'h000;
        test_reset();
        test_loadi();
        test_back_to_back();
        test_alu();
        test_shl8i();
        test_illegal();
        test_overflow();
        test_reset_mid_exec();
`ifdef STATUS_REG_EN
        test_status();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
